// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode constants and the arbiter FSM state type.
package tlul_pkg;

    // Channel A opcodes
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;

    // Channel D opcodes
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef enum logic [1:0] {
        StIdle,
        StASend,
        StDWait,
        StDSend
    } tlul_state_e;

endpackage

// File: rtl/tlul_rr_arb2.sv
// Two-way round-robin grant; the pointer moves only when the owner's transaction retires.
module tlul_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0: m0 wins a tie, 1: m1 wins a tie
    logic r_prio;

    // Grant the sole requester, or the prioritised one on a tie
    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~r_prio);
        gnt[1] = req[1] & (~req[0] | r_prio);
    end

    // Hand priority to the master that was not just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'b0;
        end else if (advance && (|gnt)) begin
            r_prio <= gnt[0];
        end
    end

endmodule

// File: rtl/tlul_arb2_timeout.sv
// Two-master TL-UL arbiter with a single outstanding transaction and a D-channel timeout.
module tlul_arb2_timeout
    import tlul_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH     = 3,
    parameter int unsigned OPCODE_WIDTH   = 3,
    parameter int unsigned PARAM_WIDTH    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    // master 0
    input  logic                    m0_a_valid,
    output logic                    m0_a_ready,
    input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  m0_a_param,
    input  logic [SIZE_WIDTH-1:0]   m0_a_size,
    input  logic                    m0_a_source,
    input  logic [ADDR_WIDTH-1:0]   m0_a_address,
    input  logic [MASK_WIDTH-1:0]   m0_a_mask,
    input  logic [DATA_WIDTH-1:0]   m0_a_data,
    output logic                    m0_d_valid,
    input  logic                    m0_d_ready,
    output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
    output logic [PARAM_WIDTH-1:0]  m0_d_param,
    output logic [SIZE_WIDTH-1:0]   m0_d_size,
    output logic                    m0_d_source,
    output logic                    m0_d_sink,
    output logic [DATA_WIDTH-1:0]   m0_d_data,
    output logic                    m0_d_error,
    // master 1
    input  logic                    m1_a_valid,
    output logic                    m1_a_ready,
    input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  m1_a_param,
    input  logic [SIZE_WIDTH-1:0]   m1_a_size,
    input  logic                    m1_a_source,
    input  logic [ADDR_WIDTH-1:0]   m1_a_address,
    input  logic [MASK_WIDTH-1:0]   m1_a_mask,
    input  logic [DATA_WIDTH-1:0]   m1_a_data,
    output logic                    m1_d_valid,
    input  logic                    m1_d_ready,
    output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
    output logic [PARAM_WIDTH-1:0]  m1_d_param,
    output logic [SIZE_WIDTH-1:0]   m1_d_size,
    output logic                    m1_d_source,
    output logic                    m1_d_sink,
    output logic [DATA_WIDTH-1:0]   m1_d_data,
    output logic                    m1_d_error,
    // downstream
    output logic                    s_a_valid,
    input  logic                    s_a_ready,
    output logic [OPCODE_WIDTH-1:0] s_a_opcode,
    output logic [PARAM_WIDTH-1:0]  s_a_param,
    output logic [SIZE_WIDTH-1:0]   s_a_size,
    output logic                    s_a_source,
    output logic [ADDR_WIDTH-1:0]   s_a_address,
    output logic [MASK_WIDTH-1:0]   s_a_mask,
    output logic [DATA_WIDTH-1:0]   s_a_data,
    input  logic                    s_d_valid,
    output logic                    s_d_ready,
    input  logic [OPCODE_WIDTH-1:0] s_d_opcode,
    input  logic [PARAM_WIDTH-1:0]  s_d_param,
    input  logic [SIZE_WIDTH-1:0]   s_d_size,
    input  logic                    s_d_source,
    input  logic                    s_d_sink,
    input  logic [DATA_WIDTH-1:0]   s_d_data,
    input  logic                    s_d_error
);

    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tlul_state_e r_state, w_state_d;
    logic        r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [OPCODE_WIDTH-1:0] r_req_opcode;
    logic [PARAM_WIDTH-1:0]  r_req_param;
    logic [SIZE_WIDTH-1:0]   r_req_size;
    logic                    r_req_source;
    logic [ADDR_WIDTH-1:0]   r_req_address;
    logic [MASK_WIDTH-1:0]   r_req_mask;
    logic [DATA_WIDTH-1:0]   r_req_data;

    logic [OPCODE_WIDTH-1:0] r_rsp_opcode;
    logic [PARAM_WIDTH-1:0]  r_rsp_param;
    logic [SIZE_WIDTH-1:0]   r_rsp_size;
    logic                    r_rsp_source;
    logic                    r_rsp_sink;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_error;

    logic [1:0] w_arb_req;
    logic [1:0] w_gnt;
    logic       w_grant;
    logic       w_owner_d_ready;
    logic       w_advance;
    logic       w_timeout;
    logic [OPCODE_WIDTH-1:0] w_err_opcode;

    // Outside IDLE the arbiter sees only the owner, so its grant names the owner on advance
    assign w_arb_req       = (r_state == StIdle) ? {m1_a_valid, m0_a_valid} : {r_owner, ~r_owner};
    assign w_grant         = (r_state == StIdle) && (|w_gnt);
    assign w_owner_d_ready = r_owner ? m1_d_ready : m0_d_ready;
    assign w_advance       = (r_state == StDSend) && w_owner_d_ready;
    assign w_cnt_inc       = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    // A real beat in the same cycle always wins over the timeout
    assign w_timeout       = (TIMEOUT_CYCLES != 0) && (r_state == StDWait) && !s_d_valid &&
                             (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign w_err_opcode    = (r_req_opcode == OPCODE_WIDTH'(Get)) ?
                             OPCODE_WIDTH'(AccessAckData) : OPCODE_WIDTH'(AccessAck);

    tlul_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_arb_req),
        .advance (w_advance),
        .gnt     (w_gnt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_grant) w_state_d = StASend;
            StASend: if (s_a_ready) w_state_d = StDWait;
            StDWait: if (s_d_valid || w_timeout) w_state_d = StDSend;
            StDSend: if (w_owner_d_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // FSM outputs; IDLE-driven handshakes are masked while reset is held
    always_comb begin
        m0_a_ready = reset && w_grant && w_gnt[0];
        m1_a_ready = reset && w_grant && w_gnt[1];
        s_a_valid  = (r_state == StASend);
        s_d_ready  = reset && ((r_state == StIdle) || (r_state == StDWait));
        m0_d_valid = (r_state == StDSend) && !r_owner;
        m1_d_valid = (r_state == StDSend) && r_owner;
    end

    // Timeout counter: counts quiet D_WAIT cycles, cleared whenever D_WAIT is not held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((r_state == StDWait) && (w_state_d == StDWait)) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end

    // Request/response capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner       <= 1'b0;
            r_req_opcode  <= '0;
            r_req_param   <= '0;
            r_req_size    <= '0;
            r_req_source  <= 1'b0;
            r_req_address <= '0;
            r_req_mask    <= '0;
            r_req_data    <= '0;
            r_rsp_opcode  <= '0;
            r_rsp_param   <= '0;
            r_rsp_size    <= '0;
            r_rsp_source  <= 1'b0;
            r_rsp_sink    <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_error   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner       <= w_gnt[1];
                r_req_opcode  <= w_gnt[1] ? m1_a_opcode  : m0_a_opcode;
                r_req_param   <= w_gnt[1] ? m1_a_param   : m0_a_param;
                r_req_size    <= w_gnt[1] ? m1_a_size    : m0_a_size;
                r_req_source  <= w_gnt[1] ? m1_a_source  : m0_a_source;
                r_req_address <= w_gnt[1] ? m1_a_address : m0_a_address;
                r_req_mask    <= w_gnt[1] ? m1_a_mask    : m0_a_mask;
                r_req_data    <= w_gnt[1] ? m1_a_data    : m0_a_data;
            end
            if ((r_state == StDWait) && s_d_valid) begin
                r_rsp_opcode <= s_d_opcode;
                r_rsp_param  <= s_d_param;
                r_rsp_size   <= s_d_size;
                r_rsp_source <= s_d_source;
                r_rsp_sink   <= s_d_sink;
                r_rsp_data   <= s_d_data;
                r_rsp_error  <= s_d_error;
            end else if (w_timeout) begin
                r_rsp_opcode <= w_err_opcode;
                r_rsp_param  <= '0;
                r_rsp_size   <= r_req_size;
                r_rsp_source <= r_req_source;
                r_rsp_sink   <= 1'b0;
                r_rsp_data   <= '0;
                r_rsp_error  <= 1'b1;
            end
        end
    end

    assign s_a_opcode  = r_req_opcode;
    assign s_a_param   = r_req_param;
    assign s_a_size    = r_req_size;
    assign s_a_source  = r_req_source;
    assign s_a_address = r_req_address;
    assign s_a_mask    = r_req_mask;
    assign s_a_data    = r_req_data;

    assign m0_d_opcode = r_rsp_opcode;
    assign m0_d_param  = r_rsp_param;
    assign m0_d_size   = r_rsp_size;
    assign m0_d_source = r_rsp_source;
    assign m0_d_sink   = r_rsp_sink;
    assign m0_d_data   = r_rsp_data;
    assign m0_d_error  = r_rsp_error;
    assign m1_d_opcode = r_rsp_opcode;
    assign m1_d_param  = r_rsp_param;
    assign m1_d_size   = r_rsp_size;
    assign m1_d_source = r_rsp_source;
    assign m1_d_sink   = r_rsp_sink;
    assign m1_d_data   = r_rsp_data;
    assign m1_d_error  = r_rsp_error;

endmodule

// File: doc/tlul_arb2_timeout.md
TLUL_ARB2_TIMEOUT -- requirements
Module: tlul_arb2_timeout

Interface
REQ-001 SHALL have parameters ADDR_WIDTH 32, DATA_WIDTH 32, MASK_WIDTH DATA_WIDTH/8, SIZE_WIDTH 3, OPCODE_WIDTH 3, PARAM_WIDTH 3, TIMEOUT_CYCLES 64 (0 = timeout disabled).
REQ-002 SHALL have `clk  in  1`: the single clock. All state is on its rising edge.
REQ-003 SHALL have `reset  in  1`: asynchronous, active-low reset.
REQ-004 SHALL have `m0_a_valid/m1_a_valid  in  1` and `m0_a_ready/m1_a_ready  out  1`: per-master channel A handshake.
REQ-005 SHALL have per-master channel A fields `mN_a_opcode/param/size/source/address/mask/data  in`, with widths per the parameters; source is 1 bit.
REQ-006 SHALL have `m0_d_valid/m1_d_valid  out  1` and `m0_d_ready/m1_d_ready  in  1`: per-master channel D handshake.
REQ-007 SHALL have `mN_d_opcode/param/size/source/sink/data/error  out`: per-master channel D fields; sink and error are 1 bit.
REQ-008 SHALL have `s_a_valid  out  1`, `s_a_ready  in  1`, and `s_a_opcode..s_a_data  out`: the downstream channel A toward the interconnect master port.
REQ-009 SHALL have `s_d_valid  in  1`, `s_d_ready  out  1`, and `s_d_opcode..s_d_error  in`: the downstream channel D.

Function
REQ-010 SHALL implement an FSM with states IDLE, A_SEND, D_WAIT, D_SEND, allowing one outstanding transaction in total.
REQ-011 IDLE: if any mN_a_valid=1, SHALL grant one master and assert only that master's mN_a_ready combinationally in the same cycle.
REQ-012 IDLE grant: SHALL capture that master's A fields into a request register and go to A_SEND; mN_a_ready SHALL be 0 in every other state.
REQ-013 Arbitration SHALL be round-robin: when both masters are valid, the master not granted last wins; after reset m0 has priority.
REQ-014 A_SEND: SHALL drive s_a_valid=1 with the registered fields, held stable until s_a_ready=1, then go to D_WAIT.
REQ-015 Request latency: SHALL be master handshake in cycle N, s_a_valid in cycle N+1.
REQ-016 D_WAIT: SHALL drive s_d_ready=1; on s_d_valid=1, capture the D fields into a response register and go to D_SEND.
REQ-017 D_WAIT: a counter SHALL increment each cycle without s_d_valid.
REQ-018 Timeout: when the counter reaches TIMEOUT_CYCLES (nonzero), SHALL synthesise an error response and go to D_SEND.
REQ-019 Synthesised error response: d_error=1, d_data=0, d_param=0, d_sink=0, d_size/d_source copied from the request.
REQ-020 Synthesised error opcode: AccessAckData(1) if the request opcode was Get(4), else AccessAck(0).
REQ-021 If s_d_valid and timeout coincide in the same cycle, SHALL take the real response; the counter SHALL clear on leaving D_WAIT.
REQ-022 D_SEND: SHALL assert d_valid only to the granted master, holding the fields stable until that master's d_ready=1.
REQ-023 D_SEND handshake: SHALL then return to IDLE and update the round-robin pointer; the other master's d_valid SHALL stay 0 throughout.
REQ-024 IDLE: SHALL drive s_d_ready=1 and silently discard any s_d_valid beat (a late response after timeout).
REQ-025 A_SEND and D_SEND: SHALL drive s_d_ready=0.
REQ-026 Counter width: SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; the counter SHALL saturate and never wrap.
REQ-027 Response pass-through: SHALL pass master source and all fields through unmodified, except for synthesised errors.
REQ-028 Back-to-back: SHALL take a new IDLE grant in the cycle after the D_SEND handshake, giving at most one transaction per 4 cycles at zero wait.

Reset
REQ-029 Reset assertion: SHALL asynchronously force state=IDLE, round-robin pointer to m0 priority, counter=0, and request/response registers=0.
REQ-030 During reset: all valid/ready outputs SHALL be 0 and all field outputs SHALL be 0.
REQ-031 Reset mid-transaction: SHALL abandon the transaction with no response issued; the first grant after deassertion obeys REQ-013.

Structure
REQ-032 Shared package `tlul_pkg` SHALL hold the opcode constants (PutFullData 0, PutPartialData 1, Get 4, AccessAck 0, AccessAckData 1) and the FSM state enum.
REQ-033 The 2-way round-robin grant logic SHALL be the single sub-module `tlul_rr_arb2` (inputs req[1:0], advance; output gnt[1:0]).

Verification
REQ-034 Bench SHALL cover a single master: m0 Get to 0x1000, slave returns data 0xDEADBEEF after 3 cycles -> m0_d_valid with that data, error=0, and m1 untouched.
REQ-035 Bench SHALL cover contention: both masters valid continuously for 4 transactions -> grants m0, m1, m0, m1, with each response routed to its requester.
REQ-036 Bench SHALL cover timeout: TIMEOUT_CYCLES=8, slave never responds to a Get -> error AccessAckData with data 0 exactly 8 cycles after D_WAIT entry; a late slave beat in IDLE is dropped.
REQ-037 Bench SHALL cover backpressure: s_a_ready low 5 cycles, then m1_d_ready low 4 cycles -> s_a_* and m1_d_* held stable throughout, and exactly one transfer each.
REQ-038 Bench SHALL cover reset in D_WAIT: reset asserted, then released -> all outputs 0, no d_valid emitted, and the next request granted to m0 when both are valid.
